demux_steer: RTL

Frame steering controller that sits directly upstream of the 1-to-2 demultiplexer and drives its select (S) and serial data (X) inputs. It accepts a parallel word plus a destination bit over a valid/ready handshake. It then holds S at the destination for the whole frame and serializes the word LSB-first onto X, with an optional parity bit and a configurable inter-frame gap. A downstream consumer on either demux output samples X while FRAME is high.

---
 rtl/demux_steer_pkg.sv | 23 ++
 rtl/demux_steer_piso.sv | 32 +++
 rtl/demux_steer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/demux_steer_pkg.sv
// demux_steer_pkg: shared types and constants for the demux steering block.
// Holds the FSM state encoding, the gap counter width and the destination
// type that drives the demultiplexer select.
package demux_steer_pkg;

    // Controller states; PAR is only reachable when PARITY_EN is defined
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Width of the inter-frame gap counter (GAP_CYC is at most 15)
    localparam int GAP_CNT_W = 4;

    // Demux destination: value placed on the select line S
    typedef enum logic {
        DEST_A = 1'b0,
        DEST_B = 1'b1
    } dest_t;

endpackage

// File: rtl/demux_steer_piso.sv
// steer_piso: DATA_W parallel-in serial-out shift register.
// Load has priority over shift; shifting is to the right with zero fill so
// that the word leaves LSB-first on o_bit0.
module steer_piso
    import demux_steer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit0
);

    logic [DATA_W-1:0] r_sr;

    // Load a new word on accept, otherwise shift one bit toward bit 0
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[DATA_W-1:1]};
        end
    end

    assign o_bit0 = r_sr[0];

endmodule

// File: rtl/demux_steer.sv
// demux_steer: frame steering controller in front of a 1-to-2 demux.
// Accepts a word plus destination over valid/ready, holds S at the
// destination and serializes the word LSB-first on X while FRAME is high,
// then pulses DONE and idles GAP_CYC cycles before the next accept.
// Optional feature macro: PARITY_EN appends an even-parity bit to each frame.
module demux_steer
    import demux_steer_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_DEST,
    output logic              S,
    output logic              X,
    output logic              FRAME,
    output logic              DONE
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    // Counter value while the final payload bit is on X
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Gap counter value in the final idle cycle of the gap
    localparam logic [GAP_CNT_W-1:0] GAP_LAST =
        GAP_CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    // Where the FSM goes once the last frame bit has been sent
    localparam state_t POST_FRAME = (GAP_CYC == 0) ? IDLE : GAP;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    dest_t                  r_sel;
    logic                   r_done;
    logic                   r_par;

    logic w_accept;
    logic w_shift;
    logic w_bit0;

    // Inputs are only looked at in IDLE, so any data change later is ignored
    assign w_accept = IN_VALID && (r_state == IDLE);
    assign w_shift  = (r_state == SHIFT);

    steer_piso #(
        .DATA_W (DATA_W)
    ) u_piso (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (IN_DATA),
        .o_bit0  (w_bit0)
    );

    // Frame sequencer: accept, shift DATA_W bits, optional parity, gap
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_sel     <= DEST_A;
            r_done    <= 1'b0;
            r_par     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        r_sel     <= dest_t'(IN_DEST);
                        r_bit_cnt <= '0;
`ifdef PARITY_EN
                        r_par     <= ^IN_DATA;
`endif
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Counts up to DATA_W at most, which fits CNT_W bits
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef PARITY_EN
                        r_state   <= PAR;
`else
                        r_done    <= 1'b1;
                        r_gap_cnt <= '0;
                        r_state   <= POST_FRAME;
`endif
                    end
                end
`ifdef PARITY_EN
                PAR: begin
                    r_done    <= 1'b1;
                    r_gap_cnt <= '0;
                    r_state   <= POST_FRAME;
                end
`endif
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no input-to-output paths
    assign IN_READY = (r_state == IDLE);
    assign S        = r_sel;
    assign DONE     = r_done;
`ifdef PARITY_EN
    assign FRAME    = (r_state == SHIFT) || (r_state == PAR);
    assign X        = (r_state == SHIFT) ? w_bit0 :
                      (r_state == PAR)   ? r_par  : 1'b0;
`else
    assign FRAME    = (r_state == SHIFT);
    assign X        = (r_state == SHIFT) ? w_bit0 : 1'b0;
`endif

endmodule
